// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters with registered sync, blanking and frame strobe.
// Define VGA_FRAME_CNT_EN to add an 8-bit wrapping frame counter output (frame_cnt).
module vga_sync #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       px_ce,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       hsync,
  output logic       vsync,
  output logic       activevideo,
  output logic       frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       wrap_frame;

  always_comb begin
    x_nxt      = x_px + 10'd1;
    y_nxt      = y_px;
    wrap_frame = 1'b0;
    if (x_px == H_MAX) begin
      x_nxt = '0;
      if (y_px == V_MAX) begin
        y_nxt      = '0;
        wrap_frame = 1'b1;
      end else begin
        y_nxt = y_px + 10'd1;
      end
    end
  end

  // Decoded outputs are computed from the next counter values so every
  // registered output describes the same (x_px, y_px) as the counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      x_px        <= '0;
      y_px        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      activevideo <= 1'b1;
      frame_end   <= 1'b0;
    end else if (px_ce) begin
      x_px        <= x_nxt;
      y_px        <= y_nxt;
      hsync       <= (x_nxt >= HS_START && x_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (y_nxt >= VS_START && y_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
      activevideo <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_end   <= wrap_frame;
    end else begin
      frame_end   <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt <= '0;
    end else if (px_ce && wrap_frame) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
